// File: rtl/retire_ctrl_pkg.sv
// Shared retire/commit configuration: ROB geometry, ROB entry layout, retire FSM states
// and the count_one popcount helper.
package retire_ctrl_pkg;

    localparam int COMMIT_WIDTH     = 2;
    localparam int ROB_SIZE         = 8;
    localparam int ROB_ID_WIDTH     = $clog2(ROB_SIZE);
    localparam int PHY_REG_ID_WIDTH = 6;
    localparam int POP_CNT_WIDTH    = $clog2(COMMIT_WIDTH + 1);

    typedef struct packed {
        logic                        finish;
        logic                        has_exception;
        logic [31:0]                 pc;
        logic [4:0]                  rd;
        logic                        rd_valid;
        logic [PHY_REG_ID_WIDTH-1:0] new_phy_id;
        logic [PHY_REG_ID_WIDTH-1:0] old_phy_id;
    } rob_item_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        WALK   = 2'd1,
        FLUSH  = 2'd2
    } retire_state_t;

    function automatic logic [POP_CNT_WIDTH-1:0] count_one(input logic [COMMIT_WIDTH-1:0] v);
        logic [POP_CNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) n = n + POP_CNT_WIDTH'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/retire_ctrl.sv
// In-order retire control: retires up to COMMIT_WIDTH finished ROB entries per cycle, and on an
// exception walks the ROB youngest-first undoing renames before flushing and redirecting.
// Optional retired-instruction counter enabled by defining RETIRE_PERF_COUNTER_EN.
module retire_ctrl
    import retire_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,

    input  logic [ROB_ID_WIDTH-1:0]     rob_commit_retire_head_id,
    input  logic                        rob_commit_retire_head_id_valid,
    output logic [ROB_ID_WIDTH-1:0]     commit_rob_retire_id [0:COMMIT_WIDTH-1],
    input  rob_item_t                   rob_commit_retire_data [0:COMMIT_WIDTH-1],
    input  logic [COMMIT_WIDTH-1:0]     rob_commit_retire_id_valid,
    output logic [COMMIT_WIDTH-1:0]     commit_rob_retire_pop,

    input  logic [ROB_ID_WIDTH-1:0]     rob_commit_flush_tail_id,
    input  logic                        rob_commit_flush_tail_id_valid,
    output logic [ROB_ID_WIDTH-1:0]     commit_rob_flush_id,
    input  rob_item_t                   rob_commit_flush_data,
    output logic                        commit_rob_flush,

    output logic [PHY_REG_ID_WIDTH-1:0] commit_free_phy_id [0:COMMIT_WIDTH-1],
    output logic [COMMIT_WIDTH-1:0]     commit_free_phy_valid,

    output logic [4:0]                  commit_rat_restore_arch_id,
    output logic [PHY_REG_ID_WIDTH-1:0] commit_rat_restore_phy_id,
    output logic                        commit_rat_restore_valid,
    output logic [PHY_REG_ID_WIDTH-1:0] commit_phy_release_id,
    output logic                        commit_phy_release_valid,

    output logic [31:0]                 commit_redirect_pc,
    output logic                        commit_redirect_valid
`ifdef RETIRE_PERF_COUNTER_EN
    ,
    output logic [63:0]                 commit_retired_count
`endif
);

    retire_state_t               state, state_nxt;
    logic [ROB_ID_WIDTH-1:0]     walk_ptr, walk_ptr_nxt;
    logic [31:0]                 redirect_pc_q, redirect_pc_nxt;

    logic [ROB_ID_WIDTH-1:0]     slot_id [0:COMMIT_WIDTH-1];
    logic [COMMIT_WIDTH-1:0]     slot_ok;
    logic [COMMIT_WIDTH-1:0]     eligible;
    logic [COMMIT_WIDTH-1:0]     unused_lane;
    logic                        head_exc;
    logic                        unused_flush;

    for (genvar i = 0; i < COMMIT_WIDTH; i++) begin : g_lane
        assign slot_id[i]     = ROB_ID_WIDTH'((int'(rob_commit_retire_head_id) + i) % ROB_SIZE);
        assign slot_ok[i]     = rob_commit_retire_id_valid[i] && rob_commit_retire_data[i].finish
                                && !rob_commit_retire_data[i].has_exception;
        assign unused_lane[i] = ^{rob_commit_retire_data[i].rd, rob_commit_retire_data[i].new_phy_id,
                                  rob_commit_retire_data[i].pc};
    end

    assign unused_flush = ^{rob_commit_flush_tail_id_valid, rob_commit_flush_data.finish,
                            rob_commit_flush_data.has_exception, rob_commit_flush_data.pc};

    // In-order retire: a slot may only go if every older slot goes too.
    always_comb begin
        logic run;
        eligible = '0;
        run      = rob_commit_retire_head_id_valid;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            run         = run && slot_ok[i];
            eligible[i] = run;
        end
    end

    assign head_exc = rob_commit_retire_head_id_valid && rob_commit_retire_id_valid[0]
                      && rob_commit_retire_data[0].finish && rob_commit_retire_data[0].has_exception;

    always_comb begin
        state_nxt                  = state;
        walk_ptr_nxt               = walk_ptr;
        redirect_pc_nxt            = redirect_pc_q;
        commit_rob_retire_pop      = '0;
        commit_free_phy_valid      = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            commit_rob_retire_id[i] = '0;
            commit_free_phy_id[i]   = '0;
        end
        commit_rob_flush_id        = '0;
        commit_rob_flush           = 1'b0;
        commit_rat_restore_arch_id = '0;
        commit_rat_restore_phy_id  = '0;
        commit_rat_restore_valid   = 1'b0;
        commit_phy_release_id      = '0;
        commit_phy_release_valid   = 1'b0;
        commit_redirect_pc         = '0;
        commit_redirect_valid      = 1'b0;

        case (state)
            NORMAL: begin
                commit_rob_retire_pop = eligible;
                for (int i = 0; i < COMMIT_WIDTH; i++) begin
                    commit_rob_retire_id[i] = slot_id[i];
                    if (eligible[i] && rob_commit_retire_data[i].rd_valid) begin
                        commit_free_phy_valid[i] = 1'b1;
                        commit_free_phy_id[i]    = rob_commit_retire_data[i].old_phy_id;
                    end
                end
                if (head_exc) begin
                    state_nxt       = WALK;
                    walk_ptr_nxt    = rob_commit_flush_tail_id;
                    redirect_pc_nxt = rob_commit_retire_data[0].pc;
                end
            end
            WALK: begin
                commit_rob_flush_id = walk_ptr;
                if (rob_commit_flush_data.rd_valid) begin
                    commit_rat_restore_valid   = 1'b1;
                    commit_rat_restore_arch_id = rob_commit_flush_data.rd;
                    commit_rat_restore_phy_id  = rob_commit_flush_data.old_phy_id;
                    commit_phy_release_valid   = 1'b1;
                    commit_phy_release_id      = rob_commit_flush_data.new_phy_id;
                end
                // The excepting entry sits at the head; undoing it ends the walk.
                if (walk_ptr == rob_commit_retire_head_id) begin
                    state_nxt = FLUSH;
                end else begin
                    walk_ptr_nxt = (walk_ptr == '0) ? ROB_ID_WIDTH'(ROB_SIZE - 1)
                                                    : walk_ptr - ROB_ID_WIDTH'(1);
                end
            end
            FLUSH: begin
                commit_rob_flush      = 1'b1;
                commit_redirect_valid = 1'b1;
                commit_redirect_pc    = redirect_pc_q;
                state_nxt             = NORMAL;
            end
            default: state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= NORMAL;
            walk_ptr      <= '0;
            redirect_pc_q <= '0;
        end else begin
            state         <= state_nxt;
            walk_ptr      <= walk_ptr_nxt;
            redirect_pc_q <= redirect_pc_nxt;
        end
    end

`ifdef RETIRE_PERF_COUNTER_EN
    logic [63:0] retired_cnt;

    always_ff @(posedge clk) begin
        if (!rst) retired_cnt <= '0;
        else      retired_cnt <= retired_cnt + 64'(count_one(commit_rob_retire_pop));
    end

    assign commit_retired_count = retired_cnt;
`endif

endmodule

// File: doc/retire_ctrl.md
RETIRE_CTRL -- requirements
Module: retire_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-low reset.
REQ-002 SHALL have ports: rob_commit_retire_head_id  in  ROB_ID_WIDTH  oldest ROB entry id; rob_commit_retire_head_id_valid  in  1  ROB non-empty.
REQ-003 SHALL have ports: commit_rob_retire_id[0:COMMIT_WIDTH-1]  out  ROB_ID_WIDTH each  ids probed, head+i mod ROB_SIZE; rob_commit_retire_data[0:COMMIT_WIDTH-1]  in  rob_item_t  entry contents; rob_commit_retire_id_valid  in  COMMIT_WIDTH  probed id occupied.
REQ-004 SHALL have ports: commit_rob_retire_pop  out  COMMIT_WIDTH  entries retired this cycle.
REQ-005 SHALL have ports: rob_commit_flush_tail_id/_valid  in  ROB_ID_WIDTH/1  youngest entry; commit_rob_flush_id  out  ROB_ID_WIDTH  walk pointer; rob_commit_flush_data  in  rob_item_t; commit_rob_flush  out  1  clears ROB.
REQ-006 SHALL have ports: commit_free_phy_id[0:COMMIT_WIDTH-1]  out  PHY_REG_ID_WIDTH; commit_free_phy_valid  out  COMMIT_WIDTH  release old mapping.
REQ-007 SHALL have ports: commit_rat_restore_arch_id  out  5; commit_rat_restore_phy_id  out  PHY_REG_ID_WIDTH; commit_rat_restore_valid  out  1  undo one rename; commit_phy_release_id/_valid  out  PHY_REG_ID_WIDTH/1  free squashed new mapping.
REQ-008 SHALL have ports: commit_redirect_pc  out  32; commit_redirect_valid  out  1  exception redirect.

Function
REQ-009 SHALL implement states NORMAL, WALK, FLUSH (2-bit register).
REQ-010 NORMAL: slot i eligible iff head valid, retire_id_valid[i], data[i].finish, !data[i].has_exception, and all slots j<i eligible; pop = eligible mask (contiguous from bit 0), combinational same cycle.
REQ-011 NORMAL: for each popped slot with rd_valid, free_phy_valid[i]=1, free_phy_id[i]=old_phy_id.
REQ-012 NORMAL: if slot 0 finished with has_exception, pop=0; latch exception pc into redirect register; latch walk pointer = flush_tail_id; next state WALK.
REQ-013 Exception at slot i>0 SHALL retire slots 0..i-1 only; exception handled when it reaches slot 0.
REQ-014 WALK: one entry per cycle, youngest first; commit_rob_flush_id = walk pointer; if entry rd_valid: rat_restore_valid=1 (arch_id=rd, phy_id=old_phy_id), phy_release_valid=1 (new_phy_id).
REQ-015 WALK: when walk pointer == head id (exception entry itself processed), next state FLUSH; else pointer decrements modulo ROB_SIZE (0 wraps to ROB_SIZE-1).
REQ-016 FLUSH: commit_rob_flush=1 and commit_redirect_valid=1 for exactly one cycle; next state NORMAL.
REQ-017 All outputs other than those named active in a state SHALL be 0 in that state; pop=0 in WALK and FLUSH.
REQ-018 Head invalid in NORMAL SHALL give pop=0, no free, no state change.
REQ-019 Walk of single-entry ROB (tail==head) SHALL take 1 WALK cycle then FLUSH.

Reset
REQ-020 rst low at a clock edge SHALL force state NORMAL, walk pointer 0, redirect pc 0, retired counter 0; all outputs 0 the following cycle, including mid-WALK.

Configuration
REQ-021 RETIRE_PERF_COUNTER_EN defined: SHALL add output commit_retired_count (64 bit) incremented by popcount(pop) each cycle, wrapping at 2^64; undefined: port and counter absent, no other change.

Structure
REQ-022 rob_item_t (finish, has_exception, pc, rd, rd_valid, new_phy_id, old_phy_id), ROB_ID_WIDTH, ROB_SIZE, COMMIT_WIDTH, PHY_REG_ID_WIDTH SHALL live in the shared package/config headers.
REQ-023 Popcount SHALL reuse count_one; no new sub-module.

Verification (COMMIT_WIDTH=2, ROB_SIZE=8)
REQ-024 Head=3, entries 3,4 finished, no exception -> pop=2'b11, free ids = their old_phy_id, same cycle.
REQ-025 Head=3 finished, 4 unfinished -> pop=2'b01; entry 3 rd_valid=0 -> free_phy_valid=0.
REQ-026 Head=6 exception pc 0x80000040, tail=1 -> WALK ids 1,0,7,6 on 4 cycles, then one FLUSH cycle with redirect_pc=0x80000040, then NORMAL.
REQ-027 Head=2 normal, entry 3 exception -> pop=2'b01; next cycle head=3 triggers WALK.
REQ-028 rst low during WALK -> next cycle state NORMAL, rat_restore_valid=0, commit_rob_flush=0.
REQ-029 With RETIRE_PERF_COUNTER_EN: three cycles popping 2,1,2 -> commit_retired_count=5.
